// File: rtl/maxpool2x2_stream_if.sv
// rtl/maxpool2x2_stream_if.sv - input/output stream handshake bundle for the 2x2 max-pool stage
interface maxpool2x2_stream_if #(
    parameter int value_size = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [value_size-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [value_size-1:0] out_data;
    logic                  out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - streaming 2x2 stride-2 signed max-pool with a one-row line buffer
module maxpool2x2_stream #(
    parameter int fm_width   = 5,
    parameter int fm_height  = 5,
    parameter int value_size = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    maxpool2x2_stream_if.slave   s
);
    localparam int PW = fm_width / 2;
    localparam int PH = fm_height / 2;
    localparam int CW = $clog2(fm_width);
    localparam int RW = $clog2(fm_height);

    typedef logic signed [value_size-1:0] val_t;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    val_t          pair_q, pair_d;
    val_t          linebuf_q [PW];
    val_t          linebuf_d [PW];
    val_t          out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;

    logic          in_ready;
    logic          accept;
    logic          in_region;
    logic [CW-1:0] col_half;
    val_t          lb_rd;
    val_t          din;

    function automatic val_t smax(input val_t a, input val_t b);
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        in_ready  = !out_valid_q || s.out_ready;
        accept    = s.in_valid && in_ready;
        din       = $signed(s.in_data);
        // Trailing odd column/row never completes a window and is dropped.
        in_region = ({1'b0, col_q} < (CW + 1)'(2 * PW)) &&
                    ({1'b0, row_q} < (RW + 1)'(2 * PH));
        col_half  = col_q >> 1;

        lb_rd = '0;
        for (int i = 0; i < PW; i++) begin
            if (col_half == CW'(i)) lb_rd = linebuf_q[i];
        end

        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        linebuf_d   = linebuf_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (out_valid_q && s.out_ready) out_valid_d = 1'b0;

        if (accept) begin
            if (col_q == CW'(fm_width - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(fm_height - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (in_region) begin
                if (!col_q[0]) begin
                    pair_d = din;
                end else if (!row_q[0]) begin
                    for (int i = 0; i < PW; i++) begin
                        if (col_half == CW'(i)) linebuf_d[i] = smax(pair_q, din);
                    end
                end else begin
                    // A load here overrides the handshake clear above.
                    out_data_d  = smax(lb_rd, smax(pair_q, din));
                    out_valid_d = 1'b1;
                    out_last_d  = (row_q == RW'(2 * PH - 1)) && (col_q == CW'(2 * PW - 1));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < PW; i++) linebuf_q[i] <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            for (int i = 0; i < PW; i++) linebuf_q[i] <= linebuf_d[i];
        end
    end

    assign s.in_ready  = in_ready;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_last  = out_last_q;
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb/tb_maxpool2x2_stream.sv - directed and randomized scoreboard bench for maxpool2x2_stream
module tb_maxpool2x2_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    maxpool2x2_stream_if #(.value_size(16)) ifc ();
    maxpool2x2_stream_if #(.value_size(16)) ifc4 ();

    maxpool2x2_stream #(.fm_width(5), .fm_height(5), .value_size(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (ifc.slave)
    );

    maxpool2x2_stream #(.fm_width(4), .fm_height(4), .value_size(16)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (ifc4.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [16:0] q5 [$];
    logic [16:0] q4 [$];

    bit rand_mode = 1'b0;
    bit hold_low  = 1'b0;
    bit stall_arm = 1'b0;
    int stall_cnt = 0;

    logic [15:0] v4 [16] = '{
        16'hffff, 16'h0fff, 16'hffff, 16'hffff,
        16'h8000, 16'h0001, 16'hffff, 16'hffff,
        16'h8000, 16'h8001, 16'h0010, 16'hfff0,
        16'h8002, 16'h8003, 16'h0020, 16'h7fff
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output scoreboards: compare each completed output beat against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_cnt > 0) begin
                check("stall_data", {16'd0, ifc.out_data}, 32'd8);
                check("stall_in_ready", {31'd0, ifc.in_ready}, 32'd0);
            end
            if (ifc.out_valid && ifc.out_ready) begin
                if (q5.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL extra_output5 observed=%h expected=none", {ifc.out_last, ifc.out_data});
                end else begin
                    check("out5", {15'd0, ifc.out_last, ifc.out_data}, {15'd0, q5.pop_front()});
                end
            end
            if (ifc4.out_valid && ifc4.out_ready) begin
                if (q4.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL extra_output4 observed=%h expected=none", {ifc4.out_last, ifc4.out_data});
                end else begin
                    check("out4", {15'd0, ifc4.out_last, ifc4.out_data}, {15'd0, q4.pop_front()});
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (stall_cnt > 0) begin
            stall_cnt--;
            ifc.out_ready = (stall_cnt == 0);
        end else if (stall_arm && ifc.out_valid && ifc.out_data == 16'd8) begin
            stall_arm     = 1'b0;
            stall_cnt     = 3;
            ifc.out_ready = 1'b0;
        end else if (hold_low) begin
            ifc.out_ready = 1'b0;
        end else if (rand_mode) begin
            ifc.out_ready = 1'($urandom_range(0, 1));
        end else begin
            ifc.out_ready = 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int which, input logic [15:0] v);
        int   n = 0;
        logic rdy;
        if (which == 0) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = v;
        end else begin
            ifc4.in_valid = 1'b1;
            ifc4.in_data  = v;
        end
        do begin
            @(negedge clk);
            rdy = (which == 0) ? ifc.in_ready : ifc4.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed=stalled expected=accepted");
        end
        if (which == 0) ifc.in_valid = 1'b0;
        else ifc4.in_valid = 1'b0;
    endtask

    task automatic run_frame5(input bit rnd, input int nbeats);
        logic signed [15:0] fr [25];
        logic signed [15:0] m;
        int b;
        for (int i = 0; i < 25; i++) fr[i] = rnd ? 16'($urandom) : 16'(i);
        for (int pr = 0; pr < 2; pr++) begin
            for (int pc = 0; pc < 2; pc++) begin
                b = (2 * pr) * 5 + 2 * pc;
                m = fr[b];
                if (fr[b + 1] > m) m = fr[b + 1];
                if (fr[b + 5] > m) m = fr[b + 5];
                if (fr[b + 6] > m) m = fr[b + 6];
                q5.push_back({(pr == 1 && pc == 1), m});
            end
        end
        for (int i = 0; i < nbeats; i++) begin
            if (rand_mode) idle($urandom_range(0, 2));
            send(0, fr[i]);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q5.size() != 0 || q4.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_q5_empty"}, q5.size(), 0);
        check({tag, "_q4_empty"}, q4.size(), 0);
        check({tag, "_idle_valid"}, {31'd0, ifc.out_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.in_valid   = 1'b0;
        ifc.in_data    = '0;
        ifc.out_ready  = 1'b1;
        ifc4.in_valid  = 1'b0;
        ifc4.in_data   = '0;
        ifc4.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, ifc.out_valid}, 0);
        check("rst_out_data", {16'd0, ifc.out_data}, 0);
        check("rst_out_last", {31'd0, ifc.out_last}, 0);
        check("rst_in_ready", {31'd0, ifc.in_ready}, 1);
        check("rst4_out_valid", {31'd0, ifc4.out_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Raster 5x5 frame, consumer always ready.
        run_frame5(1'b0, 25);
        drain("t1");

        // Two frames with in_valid held high across the boundary.
        run_frame5(1'b0, 25);
        run_frame5(1'b0, 25);
        drain("t4");

        // Three-cycle consumer stall while 8 is presented.
        stall_arm = 1'b1;
        run_frame5(1'b0, 25);
        drain("t3");
        check("stall_seen", {31'd0, stall_arm}, 0);

        // 4x4 signed-compare windows.
        q4.push_back({1'b0, 16'h0fff});
        q4.push_back({1'b0, 16'hffff});
        q4.push_back({1'b0, 16'h8003});
        q4.push_back({1'b1, 16'h7fff});
        for (int i = 0; i < 16; i++) send(1, v4[i]);
        drain("t2");

        // Reset mid-frame with an output pending.
        run_frame5(1'b0, 8);
        hold_low = 1'b1;
        send(0, 16'd8);
        @(negedge clk);
        check("pre_rst_valid", {31'd0, ifc.out_valid}, 1);
        check("pre_rst_data", {16'd0, ifc.out_data}, 8);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, ifc.out_valid}, 0);
        check("async_rst_data", {16'd0, ifc.out_data}, 0);
        check("async_rst_in_ready", {31'd0, ifc.in_ready}, 1);
        q5.delete();
        hold_low = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame5(1'b0, 25);
        drain("t5");

        // Random data with random source gaps and consumer backpressure.
        rand_mode = 1'b1;
        for (int f = 0; f < 20; f++) run_frame5(1'b1, 25);
        drain("t6");
        rand_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
